// File: rtl/apb_pkg.sv
// Shared APB definitions: access-FSM state encoding, strobe width and error-cause bits.
package apb_pkg;

    localparam int APB_STRB_W = 4;

    localparam logic [1:0] APB_IDLE  = 2'd0;
    localparam logic [1:0] APB_WAIT  = 2'd1;
    localparam logic [1:0] APB_READY = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = APB_IDLE,
        ST_WAIT  = APB_WAIT,
        ST_READY = APB_READY
    } apb_state_e;

    // Bit positions in an error-cause vector; any set bit yields PSLVERR.
    localparam int APB_ERR_W = 4;
    localparam int ERR_RANGE = 0;
    localparam int ERR_ALIGN = 1;
    localparam int ERR_RO    = 2;
    localparam int ERR_PRIV  = 3;

    typedef logic [APB_ERR_W-1:0] apb_err_t;

endpackage

// File: rtl/apb_wait_ctrl.sv
// APB access-phase sequencer: accepts a setup, counts wait states, then holds READY
// until the master completes (commit) or drops PSEL (abort). Advances only on PCLKEN.
module apb_wait_ctrl
    import apb_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic pclken_i,
    input  logic psel_i,
    input  logic penable_i,
    output logic accept_o,
    output logic load_o,
    output logic commit_o,
    output logic exit_o,
    output logic ready_o
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        load_o   = 1'b0;
        commit_o = 1'b0;
        exit_o   = 1'b0;
        if (pclken_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    // PENABLE without a preceding setup is ignored here.
                    if (psel_i && !penable_i) begin
                        accept_o = 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_d = ST_READY;
                            load_o  = 1'b1;
                        end else begin
                            cnt_d   = CNT_INIT;
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!psel_i) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == '0) begin
                        state_d = ST_READY;
                        load_o  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_READY: begin
                    if (!psel_i) begin
                        state_d = ST_IDLE;
                        exit_o  = 1'b1;
                    end else if (penable_i) begin
                        state_d  = ST_IDLE;
                        exit_o   = 1'b1;
                        commit_o = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ready_o = (state_q == ST_READY);

endmodule

// File: rtl/apb_reg_slave.sv
// APB register-bank slave: NUM_REGS byte-strobed word registers, read-only hardware
// slots, PSLVERR on bad accesses and a saturating error counter.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int                  ADDRWIDTH   = 16,
    parameter int                  DATAWIDTH   = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter int                  ERR_CNT_W   = 8
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          PCLKEN,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic [ADDRWIDTH-1:0]          PADDR,
    input  logic                          PWRITE,
    input  logic [DATAWIDTH-1:0]          PWDATA,
    input  logic [APB_STRB_W-1:0]         PSTRB,
    input  logic [2:0]                    PPROT,
    output logic [DATAWIDTH-1:0]          PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    input  logic [NUM_REGS*DATAWIDTH-1:0] ro_data_i,
    output logic [NUM_REGS*DATAWIDTH-1:0] regs_o,
    output logic [ERR_CNT_W-1:0]          err_count_o
);

    localparam int IDX_W  = ADDRWIDTH - 2;
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    function automatic logic [DATAWIDTH-1:0] merge_strb(input logic [DATAWIDTH-1:0] old_v,
                                                         input logic [DATAWIDTH-1:0] new_v,
                                                         input logic [APB_STRB_W-1:0] strb);
        logic [DATAWIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < APB_STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic accept, load, commit, exit_rdy, ready;

    apb_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_ctrl (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .pclken_i  (PCLKEN),
        .psel_i    (PSEL),
        .penable_i (PENABLE),
        .accept_o  (accept),
        .load_o    (load),
        .commit_o  (commit),
        .exit_o    (exit_rdy),
        .ready_o   (ready)
    );

    logic [IDX_W-1:0]  word_idx;
    logic [RIDX_W-1:0] setup_ridx;
    logic              in_range;
    apb_err_t          cause;

    assign word_idx   = PADDR[ADDRWIDTH-1:2];
    assign setup_ridx = word_idx[RIDX_W-1:0];
    assign in_range   = (32'(word_idx) < NUM_REGS);

    always_comb begin
        cause            = '0;
        cause[ERR_RANGE] = !in_range;
        cause[ERR_ALIGN] = |PADDR[1:0];
        cause[ERR_RO]    = PWRITE && in_range && RO_MASK[setup_ridx];
        cause[ERR_PRIV]  = PWRITE && !PPROT[0];
    end

    logic                  unused_prot;
    assign unused_prot = &{1'b0, PPROT[2:1]};

    logic [RIDX_W-1:0]     ridx_q;
    logic                  wr_q, err_q;
    logic [DATAWIDTH-1:0]  wdata_q;
    logic [APB_STRB_W-1:0] strb_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ridx_q  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (accept) begin
            ridx_q  <= setup_ridx;
            wr_q    <= PWRITE;
            err_q   <= |cause;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
        end
    end

    // With zero wait states READY is entered on the setup edge itself, before the
    // latched copies exist, so read data is formed from the live setup decode then.
    logic [RIDX_W-1:0]    eff_ridx;
    logic                 eff_wr, eff_err;
    logic [DATAWIDTH-1:0] rd_val;

    assign eff_ridx = accept ? setup_ridx : ridx_q;
    assign eff_wr   = accept ? PWRITE     : wr_q;
    assign eff_err  = accept ? (|cause)   : err_q;

    logic [DATAWIDTH-1:0] regs_q [NUM_REGS];
    logic [DATAWIDTH-1:0] regs_d [NUM_REGS];
    logic [DATAWIDTH-1:0] prdata_q, prdata_d;
    logic                 pslverr_q, pslverr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        rd_val = '0;
        if (!eff_err && !eff_wr) begin
            rd_val = RO_MASK[eff_ridx] ? ro_data_i[eff_ridx*DATAWIDTH +: DATAWIDTH]
                                       : regs_q[eff_ridx];
        end
    end

    always_comb begin
        regs_d    = regs_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        err_cnt_d = err_cnt_q;
        if (commit && wr_q && !err_q) begin
            regs_d[ridx_q] = merge_strb(regs_q[ridx_q], wdata_q, strb_q);
        end
        if (commit && err_q) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
        if (load) begin
            prdata_d  = rd_val;
            pslverr_d = eff_err;
        end else if (exit_rdy) begin
            prdata_d  = '0;
            pslverr_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            regs_q    <= regs_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
        assign regs_o[i*DATAWIDTH +: DATAWIDTH] = regs_q[i];
    end

    assign PRDATA      = prdata_q;
    assign PREADY      = ready;
    assign PSLVERR     = pslverr_q;
    assign err_count_o = err_cnt_q;

endmodule
